// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared definitions for the CPU-side SRAM-like memory arbiter.
//   REQ_INST / REQ_DATA : 1-bit requester IDs stored in the response ID FIFO
//   arb_state_e         : address-phase FSM states (ARB, LOCK_I, LOCK_D)
//   mem_size_e          : access size encodings carried on *_size
package cpu_mem_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: 1-bit wide requester-ID FIFO, synchronous active-low reset.
//   clk, resetn : clock, synchronous active-low reset
//   push_i, id_i: enqueue id_i (accepted when not full, or when popping same cycle)
//   pop_i       : dequeue head (ignored when empty)
//   full_o, empty_o, head_o : status and oldest ID
module arb_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] ids_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = ids_q[rd_ptr_q];

  // A pop frees its slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ids_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        ids_q[wr_ptr_q] <= id_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: shares one SRAM-like memory port between instruction
// fetch (inst_*) and data access (data_*) using the req/addr_ok/data_ok
// handshake. Address phases are arbitrated and held (locked) until accepted;
// in-order responses are routed back through a requester-ID FIFO.
//   clk, resetn      : clock, synchronous active-low reset
//   inst_* / data_*  : upstream request channels (req, wr, size, wstrb, addr,
//                      wdata in; addr_ok, data_ok, rdata out)
//   mem_*            : downstream channel (req, wr, size, wstrb, addr, wdata
//                      out; addr_ok, data_ok, rdata in)
//   OUTSTANDING      : max accepted-but-unanswered transactions (1..4)
// Build option: ARB_ROUND_ROBIN_EN -- when defined, contended arbitration
// favours the requester not granted last; otherwise data beats inst.
module cpu_sram_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  import cpu_mem_pkg::*;

  arb_state_e state_q, state_d;
  logic       owner;      // requester whose fields drive mem_*
  logic       owner_req;  // that requester's req is asserted
  logic       issue;      // mem_req before output forcing
  logic       accept;
  logic       fifo_full, fifo_empty, fifo_head;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
`endif

  // Grant selection: a lock pins ownership, otherwise arbitrate.
  always_comb begin
    owner     = REQ_DATA;
    owner_req = 1'b0;
    case (state_q)
      LOCK_I: begin
        owner     = REQ_INST;
        owner_req = inst_req;
      end
      LOCK_D: begin
        owner     = REQ_DATA;
        owner_req = data_req;
      end
      default: begin
        owner_req = inst_req | data_req;
        if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          owner = ~last_q;
`else
          owner = REQ_DATA;
`endif
        end else begin
          owner = data_req ? REQ_DATA : REQ_INST;
        end
      end
    endcase
  end

  // A response popping a full FIFO frees the slot for this cycle's push.
  assign issue  = resetn && owner_req && (!fifo_full || mem_data_ok);
  assign accept = issue && mem_addr_ok;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a full FIFO (issue low) keeps the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (issue && !mem_addr_ok) begin
          state_d = (owner == REQ_DATA) ? LOCK_D : LOCK_I;
        end
      end
      LOCK_I, LOCK_D: begin
        if (!owner_req || accept) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req = issue;
    if (owner == REQ_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
    if (!resetn) begin
      mem_wr    = 1'b0;
      mem_wstrb = '0;
    end
    inst_addr_ok = accept && (owner == REQ_INST);
    data_addr_ok = accept && (owner == REQ_DATA);
    inst_data_ok = resetn && mem_data_ok && !fifo_empty && (fifo_head == REQ_INST);
    data_data_ok = resetn && mem_data_ok && !fifo_empty && (fifo_head == REQ_DATA);
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = accept ? owner : last_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_q <= REQ_INST;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  arb_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push_i (accept),
    .id_i   (owner),
    .pop_i  (mem_data_ok),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  // A locked requester must hold req until accepted.
  lock_req_held_a: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == LOCK_I) |-> inst_req);
  lock_req_held_d: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == LOCK_D) |-> data_req);
  // Responses never arrive with nothing outstanding.
  no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    mem_data_ok |-> !fifo_empty);

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
module tb_cpu_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok;
  logic        a_mem_req, a_mem_wr;
  logic [1:0]  a_mem_size;
  logic [3:0]  a_mem_wstrb;
  logic [31:0] a_inst_rdata, a_data_rdata, a_mem_addr, a_mem_wdata;

  logic        b_inst_addr_ok, b_inst_data_ok, b_data_addr_ok, b_data_data_ok;
  logic        b_mem_req, b_mem_wr;
  logic [1:0]  b_mem_size;
  logic [3:0]  b_mem_wstrb;
  logic [31:0] b_inst_rdata, b_data_rdata, b_mem_addr, b_mem_wdata;

  int npass = 0;
  int ntot  = 0;

  cpu_sram_arbiter #(.OUTSTANDING(2)) dut_a (
    .clk(clk), .resetn(rst_a),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(a_inst_addr_ok), .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
    .mem_req(a_mem_req), .mem_wr(a_mem_wr), .mem_size(a_mem_size), .mem_wstrb(a_mem_wstrb),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  cpu_sram_arbiter #(.OUTSTANDING(4)) dut_b (
    .clk(clk), .resetn(rst_b),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(b_inst_addr_ok), .inst_data_ok(b_inst_data_ok), .inst_rdata(b_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(b_data_addr_ok), .data_data_ok(b_data_data_ok), .data_rdata(b_data_rdata),
    .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_size(b_mem_size), .mem_wstrb(b_mem_wstrb),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic irq(input logic [31:0] addr);
    inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = addr; inst_wdata = '0;
  endtask

  task automatic dwr(input logic [31:0] addr, input logic [31:0] wdata);
    data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hF; data_addr = addr; data_wdata = wdata;
  endtask

  task automatic drd(input logic [31:0] addr);
    data_req = 1; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0; data_addr = addr; data_wdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_a = 0; rst_b = 0;
    irq(32'h1C000000); dwr(32'h1C000100, 32'h12345678); mem_addr_ok = 1; mem_data_ok = 1; #1;
    ntot++; if (a_mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", a_mem_req); else npass++;
    ntot++; if (a_mem_wr !== 1'b0) $display("FAIL rst_mem_wr got %b exp 0", a_mem_wr); else npass++;
    ntot++; if (a_mem_wstrb !== 4'h0) $display("FAIL rst_mem_wstrb got %h exp 0", a_mem_wstrb); else npass++;
    ntot++; if ({a_inst_addr_ok, a_data_addr_ok} !== 2'b00) $display("FAIL rst_addr_ok got %b exp 00", {a_inst_addr_ok, a_data_addr_ok}); else npass++;
    ntot++; if ({a_inst_data_ok, a_data_data_ok} !== 2'b00) $display("FAIL rst_data_ok got %b exp 00", {a_inst_data_ok, a_data_data_ok}); else npass++;
    ntot++; if (b_mem_req !== 1'b0) $display("FAIL rst_b_mem_req got %b exp 0", b_mem_req); else npass++;
    @(negedge clk); idle(); rst_a = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk); irq(32'h1C000000); mem_addr_ok = 1; #1;
    ntot++; if (a_inst_addr_ok !== 1'b1) $display("FAIL rd_inst_addr_ok got %b exp 1", a_inst_addr_ok); else npass++;
    ntot++; if (a_mem_req !== 1'b1) $display("FAIL rd_mem_req got %b exp 1", a_mem_req); else npass++;
    ntot++; if (a_mem_addr !== 32'h1C000000) $display("FAIL rd_mem_addr got %h exp 1c000000", a_mem_addr); else npass++;
    ntot++; if (a_mem_size !== 2'd2) $display("FAIL rd_mem_size got %0d exp 2", a_mem_size); else npass++;
    ntot++; if (a_data_addr_ok !== 1'b0) $display("FAIL rd_data_addr_ok got %b exp 0", a_data_addr_ok); else npass++;
    @(negedge clk); idle(); #1;
    ntot++; if (a_inst_data_ok !== 1'b0) $display("FAIL rd_early_data_ok got %b exp 0", a_inst_data_ok); else npass++;
    ntot++; if (a_mem_req !== 1'b0) $display("FAIL rd_idle_mem_req got %b exp 0", a_mem_req); else npass++;
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'h02800C0C; #1;
    ntot++; if (a_inst_data_ok !== 1'b1) $display("FAIL rd_inst_data_ok got %b exp 1", a_inst_data_ok); else npass++;
    ntot++; if (a_inst_rdata !== 32'h02800C0C) $display("FAIL rd_rdata got %h exp 02800c0c", a_inst_rdata); else npass++;
    ntot++; if (a_data_data_ok !== 1'b0) $display("FAIL rd_data_data_ok got %b exp 0", a_data_data_ok); else npass++;
    @(negedge clk); idle();
  endtask

  task automatic test_contention();
    @(negedge clk); irq(32'h1C000000); dwr(32'h1C000100, 32'hDEADBEEF); mem_addr_ok = 1; #1;
    ntot++; if ({a_data_addr_ok, a_inst_addr_ok} !== 2'b10) $display("FAIL ct_grant0 got %b exp 10", {a_data_addr_ok, a_inst_addr_ok}); else npass++;
    ntot++; if (a_mem_addr !== 32'h1C000100) $display("FAIL ct_addr0 got %h exp 1c000100", a_mem_addr); else npass++;
    ntot++; if ({a_mem_wr, a_mem_wstrb} !== 5'h1F) $display("FAIL ct_wr_wstrb got %h exp 1f", {a_mem_wr, a_mem_wstrb}); else npass++;
    ntot++; if (a_mem_wdata !== 32'hDEADBEEF) $display("FAIL ct_wdata got %h exp deadbeef", a_mem_wdata); else npass++;
    @(negedge clk); data_req = 0; #1;
    ntot++; if ({a_data_addr_ok, a_inst_addr_ok} !== 2'b01) $display("FAIL ct_grant1 got %b exp 01", {a_data_addr_ok, a_inst_addr_ok}); else npass++;
    ntot++; if (a_mem_addr !== 32'h1C000000) $display("FAIL ct_addr1 got %h exp 1c000000", a_mem_addr); else npass++;
    @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h00000001; #1;
    ntot++; if ({a_data_data_ok, a_inst_data_ok} !== 2'b10) $display("FAIL ct_resp0 got %b exp 10", {a_data_data_ok, a_inst_data_ok}); else npass++;
    ntot++; if (a_data_rdata !== 32'h00000001) $display("FAIL ct_rdata0 got %h exp 00000001", a_data_rdata); else npass++;
    @(negedge clk); mem_data_ok = 1; #1;
    ntot++; if ({a_data_data_ok, a_inst_data_ok} !== 2'b01) $display("FAIL ct_resp1 got %b exp 01", {a_data_data_ok, a_inst_data_ok}); else npass++;
    @(negedge clk); idle();
  endtask

  task automatic test_lock();
    @(negedge clk); irq(32'h1C000040); mem_addr_ok = 0; #1;
    ntot++; if ({a_mem_req, a_inst_addr_ok} !== 2'b10) $display("FAIL lk_start got %b exp 10", {a_mem_req, a_inst_addr_ok}); else npass++;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); dwr(32'h1C000100, 32'h11223344); #1;
      ntot++; if (a_mem_addr !== 32'h1C000040) $display("FAIL lk_hold_addr c%0d got %h exp 1c000040", k, a_mem_addr); else npass++;
      ntot++; if ({a_mem_wr, a_data_addr_ok, a_inst_addr_ok} !== 3'b000) $display("FAIL lk_hold_ctl c%0d got %b exp 000", k, {a_mem_wr, a_data_addr_ok, a_inst_addr_ok}); else npass++;
    end
    @(negedge clk); mem_addr_ok = 1; #1;
    ntot++; if ({a_inst_addr_ok, a_data_addr_ok} !== 2'b10) $display("FAIL lk_accept got %b exp 10", {a_inst_addr_ok, a_data_addr_ok}); else npass++;
    ntot++; if (a_mem_addr !== 32'h1C000040) $display("FAIL lk_accept_addr got %h exp 1c000040", a_mem_addr); else npass++;
    @(negedge clk); inst_req = 0; #1;
    ntot++; if (a_data_addr_ok !== 1'b1) $display("FAIL lk_data_after got %b exp 1", a_data_addr_ok); else npass++;
    ntot++; if (a_mem_addr !== 32'h1C000100) $display("FAIL lk_data_addr got %h exp 1c000100", a_mem_addr); else npass++;
    @(negedge clk); idle(); mem_data_ok = 1; #1;
    ntot++; if ({a_inst_data_ok, a_data_data_ok} !== 2'b10) $display("FAIL lk_resp0 got %b exp 10", {a_inst_data_ok, a_data_data_ok}); else npass++;
    @(negedge clk); mem_data_ok = 1; #1;
    ntot++; if ({a_inst_data_ok, a_data_data_ok} !== 2'b01) $display("FAIL lk_resp1 got %b exp 01", {a_inst_data_ok, a_data_data_ok}); else npass++;
    @(negedge clk); idle();
  endtask

  task automatic test_full();
    @(negedge clk); irq(32'h1C000200); mem_addr_ok = 1; #1;
    ntot++; if (a_inst_addr_ok !== 1'b1) $display("FAIL fl_acc0 got %b exp 1", a_inst_addr_ok); else npass++;
    @(negedge clk); inst_addr = 32'h1C000204; #1;
    ntot++; if (a_inst_addr_ok !== 1'b1) $display("FAIL fl_acc1 got %b exp 1", a_inst_addr_ok); else npass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); inst_addr = 32'h1C000208; #1;
      ntot++; if ({a_mem_req, a_inst_addr_ok} !== 2'b00) $display("FAIL fl_stall c%0d got %b exp 00", k, {a_mem_req, a_inst_addr_ok}); else npass++;
    end
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'hAAAA0001; #1;
    ntot++; if ({a_mem_req, a_inst_addr_ok, a_inst_data_ok} !== 3'b111) $display("FAIL fl_pushpop got %b exp 111", {a_mem_req, a_inst_addr_ok, a_inst_data_ok}); else npass++;
    @(negedge clk); mem_data_ok = 0; inst_addr = 32'h1C00020C; #1;
    ntot++; if (a_mem_req !== 1'b0) $display("FAIL fl_still_full got %b exp 0", a_mem_req); else npass++;
    @(negedge clk); idle(); mem_data_ok = 1; #1;
    ntot++; if (a_inst_data_ok !== 1'b1) $display("FAIL fl_drain0 got %b exp 1", a_inst_data_ok); else npass++;
    @(negedge clk); mem_data_ok = 1; #1;
    ntot++; if (a_inst_data_ok !== 1'b1) $display("FAIL fl_drain1 got %b exp 1", a_inst_data_ok); else npass++;
    @(negedge clk); idle();
  endtask

  task automatic test_reset_outstanding();
    @(negedge clk); irq(32'h1C000300); mem_addr_ok = 1; #1;
    ntot++; if (a_inst_addr_ok !== 1'b1) $display("FAIL ro_acc0 got %b exp 1", a_inst_addr_ok); else npass++;
    @(negedge clk); inst_addr = 32'h1C000304; #1;
    ntot++; if (a_inst_addr_ok !== 1'b1) $display("FAIL ro_acc1 got %b exp 1", a_inst_addr_ok); else npass++;
    @(negedge clk); rst_a = 0; dwr(32'h1C000310, 32'h55AA55AA); mem_data_ok = 1; #1;
    ntot++; if ({a_mem_req, a_mem_wr, a_mem_wstrb} !== 6'h00) $display("FAIL ro_mem_out got %h exp 00", {a_mem_req, a_mem_wr, a_mem_wstrb}); else npass++;
    ntot++; if ({a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok} !== 4'h0) $display("FAIL ro_oks got %b exp 0000", {a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok}); else npass++;
    @(negedge clk); rst_a = 1; idle(); irq(32'h1C000308); mem_addr_ok = 1; #1;
    ntot++; if (a_inst_addr_ok !== 1'b1) $display("FAIL ro_post0 got %b exp 1", a_inst_addr_ok); else npass++;
    @(negedge clk); inst_addr = 32'h1C00030C; #1;
    ntot++; if (a_inst_addr_ok !== 1'b1) $display("FAIL ro_post1 got %b exp 1", a_inst_addr_ok); else npass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); idle(); mem_data_ok = 1; #1;
      ntot++; if (a_inst_data_ok !== 1'b1) $display("FAIL ro_drain c%0d got %b exp 1", k, a_inst_data_ok); else npass++;
    end
    @(negedge clk); idle(); rst_a = 0; rst_b = 1;
  endtask

  task automatic test_mixed();
    @(negedge clk); irq(32'h1C000400); mem_addr_ok = 1; #1;
    ntot++; if (b_inst_addr_ok !== 1'b1) $display("FAIL mx_acc_i0 got %b exp 1", b_inst_addr_ok); else npass++;
    @(negedge clk); inst_req = 0; drd(32'h1C000500); #1;
    ntot++; if (b_data_addr_ok !== 1'b1) $display("FAIL mx_acc_d got %b exp 1", b_data_addr_ok); else npass++;
    @(negedge clk); data_req = 0; irq(32'h1C000404); #1;
    ntot++; if (b_inst_addr_ok !== 1'b1) $display("FAIL mx_acc_i1 got %b exp 1", b_inst_addr_ok); else npass++;
    @(negedge clk); idle(); mem_data_ok = 1; mem_rdata = 32'h11110000; #1;
    ntot++; if ({b_inst_data_ok, b_data_data_ok} !== 2'b10) $display("FAIL mx_resp0 got %b exp 10", {b_inst_data_ok, b_data_data_ok}); else npass++;
    ntot++; if (b_inst_rdata !== 32'h11110000) $display("FAIL mx_rdata0 got %h exp 11110000", b_inst_rdata); else npass++;
    @(negedge clk); mem_data_ok = 1; mem_rdata = 32'h22220000; #1;
    ntot++; if ({b_inst_data_ok, b_data_data_ok} !== 2'b01) $display("FAIL mx_resp1 got %b exp 01", {b_inst_data_ok, b_data_data_ok}); else npass++;
    ntot++; if (b_data_rdata !== 32'h22220000) $display("FAIL mx_rdata1 got %h exp 22220000", b_data_rdata); else npass++;
    @(negedge clk); mem_data_ok = 1; #1;
    ntot++; if ({b_inst_data_ok, b_data_data_ok} !== 2'b10) $display("FAIL mx_resp2 got %b exp 10", {b_inst_data_ok, b_data_data_ok}); else npass++;
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_d;   // bit k set: data wins contended cycle k
    logic [31:0] exp_addr;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      irq(32'h1C000600 + 32'(4 * k)); dwr(32'h1C000700 + 32'(4 * k), 32'(k + 1)); mem_addr_ok = 1; #1;
      exp_addr = exp_d[k] ? 32'h1C000700 + 32'(4 * k) : 32'h1C000600 + 32'(4 * k);
      ntot++; if ({b_data_addr_ok, b_inst_addr_ok} !== {exp_d[k], ~exp_d[k]}) $display("FAIL bb_grant c%0d got %b exp %b", k, {b_data_addr_ok, b_inst_addr_ok}, {exp_d[k], ~exp_d[k]}); else npass++;
      ntot++; if (b_mem_addr !== exp_addr) $display("FAIL bb_addr c%0d got %h exp %h", k, b_mem_addr, exp_addr); else npass++;
      ntot++; if ({b_mem_req, b_mem_wr, b_mem_wstrb, b_mem_size} !== {1'b1, exp_d[k], {4{exp_d[k]}}, 2'd2}) $display("FAIL bb_ctl c%0d got %h exp %h", k, {b_mem_req, b_mem_wr, b_mem_wstrb, b_mem_size}, {1'b1, exp_d[k], {4{exp_d[k]}}, 2'd2}); else npass++;
      ntot++; if (b_mem_wdata !== (exp_d[k] ? 32'(k + 1) : 32'h0)) $display("FAIL bb_wdata c%0d got %h exp %h", k, b_mem_wdata, exp_d[k] ? 32'(k + 1) : 32'h0); else npass++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); mem_data_ok = 1; #1;
      ntot++; if ({b_data_data_ok, b_inst_data_ok} !== {exp_d[k], ~exp_d[k]}) $display("FAIL bb_resp c%0d got %b exp %b", k, {b_data_data_ok, b_inst_data_ok}, {exp_d[k], ~exp_d[k]}); else npass++;
    end
    @(negedge clk); idle();
  endtask

  initial begin
    rst_a = 0; rst_b = 0;
    idle();
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_full();
    test_reset_outstanding();
    test_mixed();
    test_back_to_back();
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", npass, ntot);
    $fatal(1);
  end

endmodule
